// File: rtl/inst_mem_responder.sv
// Instruction-fetch memory responder: a word array answering one fetch at a time,
// with a fixed request-to-response latency, flush cancellation and a side load port.
module inst_mem_responder #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [WIDTH-1:0]     req_addr,
    output logic                 req_ready,
    input  logic                 flush,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WIDTH-1:0]     resp_inst,
    output logic [WIDTH-1:0]     resp_pc,
    output logic                 resp_err,
    input  logic                 ld_en,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [WIDTH-1:0]     ld_data
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t               state, state_next;
    logic [3:0]           cnt, cnt_next;
    logic [WIDTH-1:0]     mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] rd_idx;
    logic                 rd_err;
    logic                 accept;

    assign rd_idx     = req_addr[ADDR_BITS+1:2];
    assign rd_err     = (req_addr[1:0] != 2'b00);
    assign resp_valid = (state == RESP);

    // NOTE: the word array has no reset; program contents must survive rst,
    // and leaving it out lets synthesis map it onto RAM.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        if (!rst && !flush) begin
            req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
        end
        accept = req_valid && req_ready;

        case (state)
            IDLE: ;
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A new acceptance overrides the consume-to-IDLE path, giving back-to-back fetches.
        if (accept) begin
            state_next = (LATENCY == 1) ? RESP : WAIT;
            cnt_next   = CNT_LOAD;
        end

        // A redirect drops whatever is in flight, including an unconsumed response.
        if (flush) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            resp_pc   <= '0;
            resp_inst <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            // The array read sees pre-write contents when ld_en hits the same word.
            if (accept) begin
                resp_pc   <= req_addr;
                resp_err  <= rd_err;
                resp_inst <= rd_err ? '0 : mem[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench: two responders (LATENCY=1 and LATENCY=2) share stimulus and are
// compared each cycle against a transaction-level model keyed on response due-cycles.
module tb_inst_mem_responder;

    localparam int W  = 32;
    localparam int AB = 8;

    logic          clk = 1'b0;
    logic          rst, req_valid, flush, resp_ready, ld_en;
    logic [W-1:0]  req_addr, ld_data;
    logic [AB-1:0] ld_addr;

    logic [1:0]    ready_o, valid_o, err_o;
    logic [W-1:0]  inst_a, inst_b, pc_a, pc_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_mem_responder #(.WIDTH(W), .ADDR_BITS(AB), .LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready_o[0]), .flush(flush), .resp_valid(valid_o[0]),
        .resp_ready(resp_ready), .resp_inst(inst_a), .resp_pc(pc_a), .resp_err(err_o[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_mem_responder #(.WIDTH(W), .ADDR_BITS(AB), .LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready_o[1]), .flush(flush), .resp_valid(valid_o[1]),
        .resp_ready(resp_ready), .resp_inst(inst_b), .resp_pc(pc_b), .resp_err(err_o[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    // Reference model: memory image plus, per DUT, the one outstanding fetch and the
    // cycle number at which its response becomes visible.
    logic [W-1:0] mm [2**AB];
    bit           busy [2];
    int           due  [2];
    logic [W-1:0] m_pc [2];
    logic [W-1:0] m_inst [2];
    bit           m_err [2];
    int           lat [2] = '{1, 2};
    int           t = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    // Inputs are already applied; compare outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit           exp_valid [2];
        bit           exp_ready [2];
        logic [W-1:0] rd;
        bit           e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_valid[k] = busy[k] && (t >= due[k]);
            exp_ready[k] = !rst && !flush && (!busy[k] || (exp_valid[k] && resp_ready));
            check($sformatf("req_ready[L%0d]", lat[k]), W'(ready_o[k]), W'(exp_ready[k]));
            check($sformatf("resp_valid[L%0d]", lat[k]), W'(valid_o[k]), W'(exp_valid[k]));
            check($sformatf("resp_pc[L%0d]", lat[k]), (k == 0) ? pc_a : pc_b, m_pc[k]);
            check($sformatf("resp_inst[L%0d]", lat[k]), (k == 0) ? inst_a : inst_b, m_inst[k]);
            check($sformatf("resp_err[L%0d]", lat[k]), W'(err_o[k]), W'(m_err[k]));
        end
        rd = mm[req_addr[AB+1:2]];
        e  = (req_addr[1:0] != 2'b00);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k] = 0; m_pc[k] = '0; m_inst[k] = '0; m_err[k] = 0;
            end else if (flush) begin
                busy[k] = 0;
            end else if (req_valid && exp_ready[k]) begin
                busy[k]   = 1;
                due[k]    = t + lat[k];
                m_pc[k]   = req_addr;
                m_err[k]  = e;
                m_inst[k] = e ? '0 : rd;
            end else if (exp_valid[k] && resp_ready) begin
                busy[k] = 0;
            end
        end
        if (ld_en) mm[ld_addr] = ld_data;
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rv, input logic [W-1:0] a, input bit rr, input bit fl, input bit r);
        req_valid  = rv;
        req_addr   = a;
        resp_ready = rr;
        flush      = fl;
        rst        = r;
        ld_en      = 1'b0;
        cycle();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        resp_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; due[k] = 0; m_pc[k] = '0; m_inst[k] = '0; m_err[k] = 0;
        end
        @(posedge clk);
        #1;

        // Fill the whole array while held in reset: loads must land despite rst.
        for (int i = 0; i < 2**AB; i++) begin
            ld_en   = 1'b1;
            ld_addr = AB'(i);
            ld_data = (i == 1) ? 32'h2402_000A : $urandom;
            cycle();
        end
        ld_en = 1'b0;

        // Single fetch of word 1.
        drive(1, 32'h0000_0004, 1, 0, 0);
        repeat (4) drive(0, 32'h0, 1, 0, 0);

        // Back-to-back fetches.
        drive(1, 32'h0000_0000, 1, 0, 0);
        drive(1, 32'h0000_0004, 1, 0, 0);
        drive(1, 32'h0000_0008, 1, 0, 0);
        repeat (4) drive(0, 32'h0, 1, 0, 0);

        // Consumer stall while a request is offered.
        drive(1, 32'h0000_000C, 0, 0, 0);
        repeat (7) drive(1, 32'h0000_0020, 0, 0, 0);
        repeat (4) drive(0, 32'h0, 1, 0, 0);

        // Flush one cycle after acceptance, then a new request right after.
        drive(1, 32'h0000_0010, 1, 0, 0);
        drive(0, 32'h0, 1, 1, 0);
        drive(1, 32'h0000_0014, 1, 0, 0);
        repeat (4) drive(0, 32'h0, 1, 0, 0);

        // Misaligned fetch.
        drive(1, 32'h0000_0006, 1, 0, 0);
        repeat (4) drive(0, 32'h0, 1, 0, 0);

        // Reset while waiting, then refetch to confirm contents survived.
        drive(1, 32'h0000_0004, 1, 0, 0);
        drive(0, 32'h0, 1, 0, 1);
        repeat (3) drive(0, 32'h0, 1, 0, 0);
        drive(1, 32'h0000_0004, 1, 0, 0);
        repeat (4) drive(0, 32'h0, 1, 0, 0);

        // Random traffic on a small window of words so loads and fetches collide.
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] a;
            a = ($urandom & 32'hFFFF_FC00) | (W'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            req_valid  = ($urandom_range(0, 9) < 6);
            req_addr   = a;
            resp_ready = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 39) == 0);
            ld_en      = ($urandom_range(0, 9) < 3);
            ld_addr    = AB'($urandom_range(0, 15));
            ld_data    = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter ADDR_BITS, default 8, word-index width (2^ADDR_BITS words).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  fetch request present.
REQ-007 SHALL have port req_addr  input  WIDTH  byte address (PC) of the fetch.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle when req_valid is also high.
REQ-009 SHALL have port flush  input  1  fetch redirect (jump/branch/EPC); cancels in-flight work.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  consumer accepts the response (low = StallF).
REQ-012 SHALL have port resp_inst  output  WIDTH  instruction word.
REQ-013 SHALL have port resp_pc  output  WIDTH  req_addr of the request being answered.
REQ-014 SHALL have port resp_err  output  1  misaligned-fetch flag.
REQ-015 SHALL have ports ld_en (input, 1), ld_addr (input, ADDR_BITS) and ld_data (input, WIDTH), forming the memory load port.

Function
REQ-016 SHALL hold a 2^ADDR_BITS x WIDTH word array, indexed by req_addr[ADDR_BITS+1:2]; upper address bits are ignored.
REQ-017 SHALL write ld_data to word ld_addr on any cycle with ld_en=1, in every state.
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-019 SHALL drive req_ready=1 in IDLE, and in RESP when resp_ready=1; otherwise 0; forced to 0 whenever flush=1.
REQ-020 SHALL accept a request on req_valid & req_ready: capture req_addr, the addressed word (old contents if ld_en hits the same word that cycle), and err = (req_addr[1:0] != 0), load counter with LATENCY-1.
REQ-021 On acceptance: LATENCY=1 -> RESP next cycle; else -> WAIT next cycle.
REQ-022 In WAIT, the counter SHALL decrement each cycle; on reaching 0, next state is RESP.
REQ-023 resp_valid SHALL be 1 exactly in RESP; resp_inst/resp_pc/resp_err SHALL be stable while resp_valid=1 and resp_ready=0.
REQ-024 resp_inst SHALL be 0 when resp_err=1.
REQ-025 In RESP with resp_ready=1: new accepted request -> WAIT, or RESP if LATENCY=1 (back-to-back); otherwise -> IDLE.
REQ-026 flush=1 in WAIT or RESP SHALL discard the captured request, no response, next state IDLE.
REQ-027 flush=1 in RESP with resp_ready=1 SHALL treat the response as not consumed and discarded.
REQ-028 Accepted-request-to-resp_valid latency SHALL be exactly LATENCY cycles, with no stall and no flush.
REQ-029 At most one request SHALL be outstanding; no queuing.

Reset
REQ-030 rst=1 SHALL force state IDLE, counter 0, resp_valid 0, resp_inst 0, resp_pc 0, resp_err 0 at the next edge; this takes priority over flush, requests and state.
REQ-031 During rst=1, req_ready SHALL be 0.
REQ-032 rst SHALL NOT clear the word array.
REQ-033 A ld_en write asserted in the same cycle as rst SHALL still take effect.
REQ-034 rst during WAIT or RESP SHALL drop the request with no response.

Verification
REQ-035 Load word 1 = 0x2402000A; request 0x00000004 in cycle 0, resp_ready=1 -> resp_valid in cycle 2 with inst 0x2402000A, pc 0x4, err 0, then IDLE.
REQ-036 Back-to-back requests 0x0, 0x4, 0x8 with resp_ready=1, LATENCY=1 -> responses on consecutive cycles, each pc matching its request.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and all data stable; req_ready=0 until resp_ready=1.
REQ-038 flush one cycle after accepting 0x10 -> no resp_valid for that request; req_ready=1 the following cycle.
REQ-039 Request 0x00000006 -> resp_err=1, resp_inst=0x00000000, resp_pc=0x6.
REQ-040 Assert rst in WAIT -> resp_valid never rises for that request; loaded word contents unchanged after reset.
